add_cmp_pipe: RTL
=================

ADD_CMP_PIPE -- requirements
Module: add_cmp_pipe

Interface
REQ-001 SHALL have parameter W, default 50: operand width.
REQ-002 SHALL have parameter TW, default 8: tag width.
REQ-003 SHALL have parameter CW, default 16: statistics counter width.
REQ-004 SHALL use one clock and an asynchronous, active-low reset, with ports clk and rst_n.
REQ-005 SHALL have port: clk  in  1  clock, all state updates on rising edge.
REQ-006 SHALL have port: rst_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have port: in_valid  in  1  operand triple valid.
REQ-008 SHALL have port: in_ready  out  1  block accepts triple this cycle.
REQ-009 SHALL have ports: in_a, in_b, in_c  in  W each  operands.
REQ-010 SHALL have port: in_tag  in  TW  opaque tag, carried with the triple.
REQ-011 SHALL have port: out_valid  out  1  result valid.
REQ-012 SHALL have port: out_ready  in  1  consumer accepts result.
REQ-013 SHALL have port: out_eq  out  1  1 iff (a+b) mod 2^W == c.
REQ-014 SHALL have port: out_tag  out  TW  tag of the reported triple.
REQ-015 SHALL have port: cnt_clr  in  1  synchronous clear of both counters.
REQ-016 SHALL have ports: match_cnt, miss_cnt  out  CW each  saturating result counts.
REQ-017 SHALL have port: busy  out  1  any pipeline stage holds valid data.

Function
REQ-018 SHALL compute eq without a carry-propagate adder; eq SHALL be AND over bits of s^k, where s=a^b^~c and k={maj(a,b,~c)[W-2:0],1'b0}.
REQ-019 SHALL register stage S1 as: v1, s, k, tag; S1 SHALL load on the in handshake (in_valid&&in_ready).
REQ-020 SHALL register stage S2 as: v2, tag, and G=ceil(W/4) group flags; each flag SHALL be the AND of 4 bits of s^k, and the last group SHALL be partial when W%4!=0 (W=50: 13 groups, last 2 bits).
REQ-021 SHALL drive out_valid from v2, out_tag from the S2 tag, and out_eq as the AND of the S2 group flags.
REQ-022 SHALL define adv2 = !v2 || out_ready, and S2 SHALL load from S1 when adv2 holds (v2 <= v1).
REQ-023 SHALL drive in_ready = !v1 || adv2: bubble-collapsing, combinational in out_ready, no combinational path from in_valid.
REQ-024 SHALL clear v1 when S1 advances with no new input accepted.
REQ-025 SHALL have latency: triple accepted in cycle N -> out_valid in cycle N+2 when unstalled.
REQ-026 SHALL sustain throughput of 1 triple/cycle.
REQ-027 SHALL buffer at most 2 results.
REQ-028 SHALL never drop, duplicate or reorder results under any backpressure.
REQ-029 SHALL hold out_eq and out_tag stable while out_valid && !out_ready.
REQ-030 SHALL increment match_cnt on an out handshake with out_eq=1, and miss_cnt on one with out_eq=0.
REQ-031 SHALL saturate both counters at 2^CW-1.
REQ-032 SHALL zero both counters next cycle on cnt_clr; if a handshake coincides, clear SHALL win and that result SHALL be uncounted.
REQ-033 SHALL drive busy = v1 | v2.

Reset
REQ-034 SHALL on rst_n low immediately clear v1, v2, s, k, group flags, tags and counters, giving out_valid=0, in_ready=1, busy=0, match_cnt=miss_cnt=0.
REQ-035 SHALL discard in-flight triples at reset mid-operation; none SHALL emerge after release.
REQ-036 SHALL take no handshake in the first cycle after release only if the synchronizer requires it; otherwise in_ready SHALL be 1.

Structure
REQ-037 SHALL place in package add_cmp_pkg: default W/TW/CW, group size 4, and a function returning G.
REQ-038 SHALL place the carry-save row (s, k generation from W full adders) in sub-module add_cmp_csa; pipeline, handshake and counters SHALL stay in add_cmp_pipe.

Verification
REQ-039 SHALL cover: a=3, b=5, c=8, tag=0x11 accepted at cycle N -> out_valid at N+2, out_eq=1, out_tag=0x11, match_cnt=1.
REQ-040 SHALL cover: a=2^50-1, b=1, c=0 -> out_eq=1 (wrap); then a=1, b=1, c=3 -> out_eq=0, miss_cnt=1.
REQ-041 SHALL cover: continuous in_valid, tags 0..9, out_ready=0 for 6 cycles -> exactly 2 accepted, in_ready=0 and outputs stable; on release, tags 0..9 delivered in order, once each.
REQ-042 SHALL cover: CW=4, 17 matching triples -> match_cnt=15; cnt_clr coincident with a handshake -> match_cnt=0 next cycle.
REQ-043 SHALL cover: rst_n low with v1=v2=1 -> out_valid=0 without a clock edge; after release, no stale result appears and a fresh triple returns at N+2.
REQ-044 SHALL cover: random a, b, with c = a+b, or c = a+b xor a single random bit, with random out_ready -> out_eq matches the reference model for 10^5 triples.

Source files
------------

// File: rtl/add_cmp_pkg.sv
// Shared parameters for the add-compare pipeline: default widths, the
// equality-check group size, and the group-count helper.
package add_cmp_pkg;

    localparam int unsigned W_DEF  = 50;
    localparam int unsigned TW_DEF = 8;
    localparam int unsigned CW_DEF = 16;
    localparam int unsigned GRP    = 4;

    // Number of GRP-bit groups covering a w-bit vector; the last one may be partial.
    function automatic int unsigned num_groups(input int unsigned w);
        return (w + GRP - 1) / GRP;
    endfunction

endpackage

// File: rtl/add_cmp_csa.sv
// Carry-save row of W full adders over (a, b, ~c).
// a+b == c (mod 2^W) exactly when s ^ k is all ones.
module add_cmp_csa #(
    parameter int unsigned W = 50
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [W-1:0] c_i,
    output logic [W-1:0] s_c,
    output logic [W-1:0] k_c
);

    logic [W-1:0] nc;

    assign nc  = ~c_i;
    assign s_c = a_i ^ b_i ^ nc;
    // The carry out of the top bit falls off the modular sum, so only W-1 majorities are kept.
    assign k_c = {(a_i[W-2:0] & b_i[W-2:0]) | (a_i[W-2:0] & nc[W-2:0]) | (b_i[W-2:0] & nc[W-2:0]),
                  1'b0};

endmodule

// File: rtl/add_cmp_pipe.sv
// Two-stage valid/ready pipeline reporting whether (a+b) mod 2^W == c,
// with saturating match/miss counters on delivered results.
module add_cmp_pipe
    import add_cmp_pkg::*;
#(
    parameter int unsigned W  = W_DEF,
    parameter int unsigned TW = TW_DEF,
    parameter int unsigned CW = CW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [W-1:0]  in_a,
    input  logic [W-1:0]  in_b,
    input  logic [W-1:0]  in_c,
    input  logic [TW-1:0] in_tag,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_eq,
    output logic [TW-1:0] out_tag,
    input  logic          cnt_clr,
    output logic [CW-1:0] match_cnt,
    output logic [CW-1:0] miss_cnt,
    output logic          busy
);

    localparam int unsigned G  = num_groups(W);
    localparam int unsigned PW = G * GRP;
    localparam logic [CW-1:0] CNT_MAX = {CW{1'b1}};

    logic [W-1:0]  s_c, k_c;

    logic          v1_q, v1_d;
    logic [W-1:0]  s1_q, s1_d;
    logic [W-1:0]  k1_q, k1_d;
    logic [TW-1:0] tag1_q, tag1_d;
    logic          v2_q, v2_d;
    logic [TW-1:0] tag2_q, tag2_d;
    logic [G-1:0]  grp_q, grp_d;
    logic [CW-1:0] match_q, match_d;
    logic [CW-1:0] miss_q, miss_d;

    logic          adv1, adv2, out_hs, eq_c;
    logic [PW-1:0] xp;
    logic [G-1:0]  grp_c;

    add_cmp_csa #(.W(W)) u_csa (
        .a_i (in_a),
        .b_i (in_b),
        .c_i (in_c),
        .s_c (s_c),
        .k_c (k_c)
    );

    // Group AND-reduction of s^k; padding bits are ones so a partial last group is neutral.
    always_comb begin
        xp        = '1;
        xp[W-1:0] = s1_q ^ k1_q;
        grp_c     = '0;
        for (int g = 0; g < int'(G); g++) begin
            grp_c[g] = &xp[g*GRP +: GRP];
        end
    end

    assign adv2   = !v2_q || out_ready;
    assign adv1   = !v1_q || adv2;
    assign out_hs = v2_q && out_ready;
    assign eq_c   = &grp_q;

    always_comb begin
        v1_d    = v1_q;
        s1_d    = s1_q;
        k1_d    = k1_q;
        tag1_d  = tag1_q;
        v2_d    = v2_q;
        tag2_d  = tag2_q;
        grp_d   = grp_q;
        match_d = match_q;
        miss_d  = miss_q;

        if (adv1) begin
            v1_d = in_valid;
            if (in_valid) begin
                s1_d   = s_c;
                k1_d   = k_c;
                tag1_d = in_tag;
            end
        end

        if (adv2) begin
            v2_d = v1_q;
            if (v1_q) begin
                tag2_d = tag1_q;
                grp_d  = grp_c;
            end
        end

        // Clear takes priority over counting a coincident handshake.
        if (cnt_clr) begin
            match_d = '0;
            miss_d  = '0;
        end else if (out_hs) begin
            if (eq_c) begin
                if (match_q != CNT_MAX) match_d = match_q + CW'(1);
            end else begin
                if (miss_q != CNT_MAX) miss_d = miss_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q    <= 1'b0;
            s1_q    <= '0;
            k1_q    <= '0;
            tag1_q  <= '0;
            v2_q    <= 1'b0;
            tag2_q  <= '0;
            grp_q   <= '0;
            match_q <= '0;
            miss_q  <= '0;
        end else begin
            v1_q    <= v1_d;
            s1_q    <= s1_d;
            k1_q    <= k1_d;
            tag1_q  <= tag1_d;
            v2_q    <= v2_d;
            tag2_q  <= tag2_d;
            grp_q   <= grp_d;
            match_q <= match_d;
            miss_q  <= miss_d;
        end
    end

    assign in_ready  = adv1;
    assign out_valid = v2_q;
    assign out_eq    = eq_c;
    assign out_tag   = tag2_q;
    assign match_cnt = match_q;
    assign miss_cnt  = miss_q;
    assign busy      = v1_q | v2_q;

endmodule
